cm0_debugslave_arbiter: RTL
===========================

// Module: cm0_debugslave_arbiter
// PURPOSE
//  Parametrised debug-slave channel: NUM_MASTERS debug masters (DAP, trace/test ports) share one Cortex-M0
//  debug slave. Round-robin arbitration, registered request/response paths, optional response timeout.
//  Sits between the debug masters and the core debug slave port, clocked by the debug clock domain.
// PARAMETERS
//  NUM_MASTERS  2    number of master ports, 1..4 (1 = registered pass-through)
//  ADDR_W       32   SLVADDR width
//  DATA_W       32   SLVWDATA/SLVRDATA width
//  TIMEOUT      0    slave-wait cycles before error abort; 0 = timeout disabled; max 65535
// PORTS
//  DCLK         in   1               debug clock, all logic on rising edge
//  DBGRESETn    in   1               synchronous active-low reset, sampled on DCLK
//  SLVTRANSMM   in   2*NUM_MASTERS   per-master transfer type; bit1 = request valid (master m at [2m+1:2m])
//  SLVSIZEMM    in   2*NUM_MASTERS   per-master transfer size
//  SLVWRITEMM   in   NUM_MASTERS     per-master write enable
//  SLVADDRMM    in   ADDR_W*NUM_MASTERS  per-master address
//  SLVWDATAMM   in   DATA_W*NUM_MASTERS  per-master write data
//  SLVRDATAMM   out  DATA_W          read data, shared, qualified by SLVREADYMM
//  SLVREADYMM   out  NUM_MASTERS     per-master transfer complete, one-hot pulse
//  SLVRESPMM    out  1               response, 1 = error, qualified by SLVREADYMM
//  SLVTRANSMS   out  2               to core: transfer type
//  SLVSIZEMS    out  2               to core: size
//  SLVWRITEMS   out  1               to core: write enable
//  SLVADDRMS    out  ADDR_W          to core: address
//  SLVWDATAMS   out  DATA_W          to core: write data
//  SLVRDATAMS   in   DATA_W          from core: read data
//  SLVREADYMS   in   1               from core: transfer complete
//  SLVRESPMS    in   1               from core: error response
//  TIMEOUTERR   out  1               sticky: set on any timeout abort, cleared only by reset
// BEHAVIOUR
//  Reset (DBGRESETn=0 at a DCLK edge): all outputs 0, state IDLE, RR pointer = 0, timer = 0, even mid-transfer.
//  Master protocol: request = SLVTRANSMM[2m+1]=1 with attributes held stable until SLVREADYMM[m]=1 (one cycle).
//  State machine:
//   IDLE: any request valid -> grant = first requester at/after RR pointer (wrapping);
//         capture its attributes into output regs; SLVTRANSMS = captured TRANS; -> REQ. No request: stay.
//   REQ : SLVTRANSMS/attributes held constant. Timer increments each cycle.
//         SLVREADYMS=1 -> capture SLVRDATAMS/SLVRESPMS; SLVTRANSMS <= 0; -> RESP.
//         TIMEOUT!=0 and timer==TIMEOUT-1 and SLVREADYMS=0 -> RDATA<=0, RESP<=1, TIMEOUTERR<=1;
//         SLVTRANSMS <= 0; -> RESP. Ready and timeout in the same cycle: ready wins.
//   RESP: SLVREADYMM[grant]=1 for exactly this cycle; RR pointer <= grant+1 (mod NUM_MASTERS);
//         timer <= 0; -> IDLE. Requests are not sampled in RESP (the granted master is still driving).
//  Latency: request seen in IDLE at edge N -> core request from N+1; core ready at edge K -> SLVREADYMM high
//   in the cycle after K. Minimum 3 cycles per transfer; back-to-back requests get one IDLE cycle between.
//  SLVREADYMS/SLVRESPMS outside REQ are ignored (a late ready after a timeout is dropped).
//  SLVRDATAMM and SLVRESPMM hold their value outside RESP; they are meaningful only with SLVREADYMM.
//  NUM_MASTERS=1: same FSM, arbitration is trivial; RR pointer is constant 0.
//  Timer width: 16 bits; no wrap is possible since an abort at TIMEOUT-1 ends REQ first.
// TESTING
//  1 Single read: M0 TRANS=2'b10 ADDR=0xE000EDF0; core READY after 2 cycles with RDATA=0x00030003 ->
//    SLVREADYMM=2'b01 one cycle, SLVRDATAMM=0x00030003, SLVRESPMM=0, core TRANS back to 0.
//  2 Contention: M0 and M1 request together, pointer=0 -> M0 served first, then M1; M0 re-requests at once
//    -> order is M0, M1, M0; never two grants in a row while the other master is waiting.
//  3 Timeout: TIMEOUT=8, core never ready -> 8 cycles of REQ, then RESP with SLVRESPMM=1, SLVRDATAMM=0,
//    TIMEOUTERR=1; a core READY 3 cycles later produces no SLVREADYMM pulse.
//  4 Ready on the timeout cycle: core READY=1, RDATA=0x12345678 exactly at timer==TIMEOUT-1 ->
//    normal response, SLVRESPMM=0, TIMEOUTERR stays 0.
//  5 Reset mid-REQ: assert DBGRESETn=0 for one edge while in REQ -> next cycle all outputs 0, the following
//    request is granted to M0 regardless of the prior pointer.
//  6 Core error: core READY=1, RESP=1 on a write from M1 -> SLVREADYMM=2'b10, SLVRESPMM=1, TIMEOUTERR=0.

Source files
------------

// File: rtl/cm0_debugslave_arbiter.sv
// Round-robin arbiter sharing one Cortex-M0 debug slave port between NUM_MASTERS debug masters.
// Latency: request seen in IDLE -> core request next cycle; core ready -> master ready one cycle later (min 3 cycles).
// Backpressure: masters hold their request until their one-cycle SLVREADYMM pulse; optional timeout aborts a stuck core.
module cm0_debugslave_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 0
) (
    input  logic                          DCLK,
    input  logic                          DBGRESETn,
    input  logic [2*NUM_MASTERS-1:0]      SLVTRANSMM,
    input  logic [2*NUM_MASTERS-1:0]      SLVSIZEMM,
    input  logic [NUM_MASTERS-1:0]        SLVWRITEMM,
    input  logic [ADDR_W*NUM_MASTERS-1:0] SLVADDRMM,
    input  logic [DATA_W*NUM_MASTERS-1:0] SLVWDATAMM,
    output logic [DATA_W-1:0]             SLVRDATAMM,
    output logic [NUM_MASTERS-1:0]        SLVREADYMM,
    output logic                          SLVRESPMM,
    output logic [1:0]                    SLVTRANSMS,
    output logic [1:0]                    SLVSIZEMS,
    output logic                          SLVWRITEMS,
    output logic [ADDR_W-1:0]             SLVADDRMS,
    output logic [DATA_W-1:0]             SLVWDATAMS,
    input  logic [DATA_W-1:0]             SLVRDATAMS,
    input  logic                          SLVREADYMS,
    input  logic                          SLVRESPMS,
    output logic                          TIMEOUTERR
);

    // Master indices fit in two bits since at most four masters are supported.
    localparam int              IDX_W   = 2;
    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [15:0]     TO_LAST = TO_EN ? 16'(TIMEOUT - 1) : 16'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         rr_q, rr_d;
    logic [IDX_W-1:0]         grant_q, grant_d;
    logic [15:0]              timer_q, timer_d;
    logic [1:0]               trans_q, trans_d;
    logic [1:0]               size_q, size_d;
    logic                     write_q, write_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [DATA_W-1:0]        wdata_q, wdata_d;
    logic [DATA_W-1:0]        rdata_q, rdata_d;
    logic                     resp_q, resp_d;
    logic [NUM_MASTERS-1:0]   ready_q, ready_d;
    logic                     toerr_q, toerr_d;

    logic [3:0]               req_pad;
    logic                     req_found;
    logic [IDX_W-1:0]         gnt_idx;
    logic [2:0]               cand;
    logic [1:0]               sel_trans;
    logic [1:0]               sel_size;
    logic                     sel_write;
    logic [ADDR_W-1:0]        sel_addr;
    logic [DATA_W-1:0]        sel_wdata;

    // Collect request-valid bits, zero-padded so any two-bit index is in range.
    always_comb begin
        req_pad = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            req_pad[m] = SLVTRANSMM[2*m+1];
        end
    end

    // Round-robin search: first requester at or after the pointer, wrapping at NUM_MASTERS.
    always_comb begin
        req_found = 1'b0;
        gnt_idx   = rr_q;
        cand      = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = {1'b0, rr_q} + 3'(i);
            if (cand >= 3'(NUM_MASTERS)) begin
                cand = cand - 3'(NUM_MASTERS);
            end
            if (!req_found && req_pad[cand[1:0]]) begin
                req_found = 1'b1;
                gnt_idx   = cand[1:0];
            end
        end
    end

    // Select the attributes of the master picked by the search.
    always_comb begin
        sel_trans = '0;
        sel_size  = '0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (IDX_W'(m) == gnt_idx) begin
                sel_trans = SLVTRANSMM[2*m +: 2];
                sel_size  = SLVSIZEMM[2*m +: 2];
                sel_write = SLVWRITEMM[m];
                sel_addr  = SLVADDRMM[ADDR_W*m +: ADDR_W];
                sel_wdata = SLVWDATAMM[DATA_W*m +: DATA_W];
            end
        end
    end

    // Next-state logic for the IDLE -> REQ -> RESP transfer sequence and all registered outputs.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        timer_d = timer_q;
        trans_d = trans_q;
        size_d  = size_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        resp_d  = resp_q;
        ready_d = '0;
        toerr_d = toerr_q;

        case (state_q)
            ST_IDLE: begin
                if (req_found) begin
                    grant_d = gnt_idx;
                    trans_d = sel_trans;
                    size_d  = sel_size;
                    write_d = sel_write;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    timer_d = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                timer_d = timer_q + 16'd1;
                // Core ready takes priority over a timeout landing on the same cycle.
                if (SLVREADYMS) begin
                    rdata_d = SLVRDATAMS;
                    resp_d  = SLVRESPMS;
                    trans_d = '0;
                    state_d = ST_RESP;
                    for (int m = 0; m < NUM_MASTERS; m++) begin
                        ready_d[m] = (IDX_W'(m) == grant_q);
                    end
                end else if (TO_EN && (timer_q == TO_LAST)) begin
                    rdata_d = '0;
                    resp_d  = 1'b1;
                    toerr_d = 1'b1;
                    trans_d = '0;
                    state_d = ST_RESP;
                    for (int m = 0; m < NUM_MASTERS; m++) begin
                        ready_d[m] = (IDX_W'(m) == grant_q);
                    end
                end
            end
            ST_RESP: begin
                // Granted master is still driving its request here, so nothing is sampled.
                rr_d    = (grant_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;
                timer_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge DCLK) begin
        if (!DBGRESETn) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            timer_q <= '0;
            trans_q <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
            ready_q <= '0;
            toerr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            timer_q <= timer_d;
            trans_q <= trans_d;
            size_q  <= size_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            ready_q <= ready_d;
            toerr_q <= toerr_d;
        end
    end

    assign SLVTRANSMS = trans_q;
    assign SLVSIZEMS  = size_q;
    assign SLVWRITEMS = write_q;
    assign SLVADDRMS  = addr_q;
    assign SLVWDATAMS = wdata_q;
    assign SLVRDATAMM = rdata_q;
    assign SLVRESPMM  = resp_q;
    assign SLVREADYMM = ready_q;
    assign TIMEOUTERR = toerr_q;

endmodule
